// File: rtl/prbs_rx_monitor.sv
// PRBS-31 receive checker: self-synchronising per-bit error detection,
// HUNT/LOCKED lock tracking and saturating bit/error/lock-loss statistics.
module prbs_rx_monitor #(
    parameter int unsigned INV_PATTERN = 1,
    parameter int unsigned LOCK_CNT    = 16,
    parameter int unsigned LOSS_CNT    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_axis_input_tdata,
    input  logic        s_axis_input_tvalid,
    input  logic        s_axis_input_tlast,
    output logic        s_axis_input_tready,
    input  logic        clear_stats,
    output logic [7:0]  err_vec,
    output logic        err_valid,
    output logic        locked,
    output logic [47:0] bit_count,
    output logic [31:0] err_count,
    output logic [15:0] lock_loss_count
);

    typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

    localparam logic        INV_BIT    = (INV_PATTERN != 0);
    localparam logic [15:0] LOCK_LIMIT = 16'(LOCK_CNT);
    localparam logic [15:0] LOSS_LIMIT = 16'(LOSS_CNT);
    localparam logic [2:0]  WARM_BEATS = 3'd4;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] s;
        s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            s = s + {3'b000, v[i]};
        end
        return s;
    endfunction

    function automatic logic [47:0] sat_add48(input logic [47:0] a, input logic [3:0] b);
        logic [48:0] s;
        s = {1'b0, a} + {45'd0, b};
        return s[48] ? {48{1'b1}} : s[47:0];
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [3:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {29'd0, b};
        return s[32] ? {32{1'b1}} : s[31:0];
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] a);
        return (a == 16'hFFFF) ? a : (a + 16'd1);
    endfunction

    logic        r_tready;
    logic [30:0] r_hist;
    logic [7:0]  r_err_vec;
    logic        r_err_valid;
    logic        r_eval;
    logic [2:0]  r_warm;
    state_t      r_state;
    logic [15:0] r_good_run;
    logic [15:0] r_bad_run;
    logic [47:0] r_bit_count;
    logic [31:0] r_err_count;
    logic [15:0] r_loss_count;
    logic        r_locked;

    logic        w_accept;
    logic        w_bit;
    logic [30:0] w_hist_nxt;
    logic [7:0]  w_err_vec;
    logic [3:0]  w_pop;
    state_t      w_state_nxt;
    logic [15:0] w_good_nxt;
    logic [15:0] w_bad_nxt;
    logic [47:0] w_bit_count_nxt;
    logic [31:0] w_err_count_nxt;
    logic [15:0] w_loss_count_nxt;
    logic        w_unused_tlast;

    assign w_unused_tlast      = s_axis_input_tlast;
    assign s_axis_input_tready = r_tready & ~rst;
    assign w_accept            = s_axis_input_tvalid & s_axis_input_tready;

    // Serially unrolled checker: tdata[7] first, every bit shifted in regardless of error.
    always_comb begin
        w_hist_nxt = r_hist;
        w_err_vec  = 8'h00;
        w_bit      = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            w_bit        = s_axis_input_tdata[i] ^ INV_BIT;
            w_err_vec[i] = w_bit ^ w_hist_nxt[30] ^ w_hist_nxt[27];
            w_hist_nxt   = {w_hist_nxt[29:0], w_bit};
        end
    end

    // Stage 1: history, error vector and warm-up tagging of each accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tready    <= 1'b0;
            r_hist      <= 31'd0;
            r_err_vec   <= 8'h00;
            r_err_valid <= 1'b0;
            r_eval      <= 1'b0;
            r_warm      <= 3'd0;
        end else begin
            r_tready    <= 1'b1;
            r_err_valid <= w_accept;
            if (w_accept) begin
                r_hist    <= w_hist_nxt;
                r_err_vec <= w_err_vec;
                r_eval    <= (r_warm == WARM_BEATS);
                if (r_warm != WARM_BEATS) begin
                    r_warm <= r_warm + 3'd1;
                end
            end
        end
    end

    // Stage 2: lock FSM and statistics; counting uses the state before this update.
    always_comb begin
        w_state_nxt      = r_state;
        w_good_nxt       = r_good_run;
        w_bad_nxt        = r_bad_run;
        w_bit_count_nxt  = r_bit_count;
        w_err_count_nxt  = r_err_count;
        w_loss_count_nxt = r_loss_count;
        w_pop            = popcount8(r_err_vec);
        if (r_err_valid && r_eval) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_pop == 4'd0) begin
                        if ((r_good_run + 16'd1) == LOCK_LIMIT) begin
                            w_state_nxt = ST_LOCKED;
                            w_good_nxt  = 16'd0;
                        end else begin
                            w_good_nxt  = r_good_run + 16'd1;
                        end
                    end else begin
                        w_good_nxt = 16'd0;
                    end
                end
                ST_LOCKED: begin
                    w_bit_count_nxt = sat_add48(r_bit_count, 4'd8);
                    w_err_count_nxt = sat_add32(r_err_count, w_pop);
                    if (w_pop != 4'd0) begin
                        if ((r_bad_run + 16'd1) == LOSS_LIMIT) begin
                            w_state_nxt      = ST_HUNT;
                            w_bad_nxt        = 16'd0;
                            w_loss_count_nxt = sat_inc16(r_loss_count);
                        end else begin
                            w_bad_nxt = r_bad_run + 16'd1;
                        end
                    end else begin
                        w_bad_nxt = 16'd0;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
        if (clear_stats) begin
            w_bit_count_nxt  = 48'd0;
            w_err_count_nxt  = 32'd0;
            w_loss_count_nxt = 16'd0;
        end else begin
            w_loss_count_nxt = w_loss_count_nxt;
        end
    end

    // Stage 2 registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_good_run   <= 16'd0;
            r_bad_run    <= 16'd0;
            r_bit_count  <= 48'd0;
            r_err_count  <= 32'd0;
            r_loss_count <= 16'd0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_good_run   <= w_good_nxt;
            r_bad_run    <= w_bad_nxt;
            r_bit_count  <= w_bit_count_nxt;
            r_err_count  <= w_err_count_nxt;
            r_loss_count <= w_loss_count_nxt;
            r_locked     <= (w_state_nxt == ST_LOCKED);
        end
    end

    assign err_vec         = r_err_vec;
    assign err_valid       = r_err_valid;
    assign locked          = r_locked;
    assign bit_count       = r_bit_count;
    assign err_count       = r_err_count;
    assign lock_loss_count = r_loss_count;

endmodule

// File: tb/tb_prbs_rx_monitor.sv
// Self-checking bench for prbs_rx_monitor: directed lock/loss/clear/reset scenarios
// plus randomized traffic against a bit-history reference model.
module tb_prbs_rx_monitor;

    localparam int INV  = 1;
    localparam int LOCK = 16;
    localparam int LOSS = 4;
    localparam bit INV_B = (INV != 0);

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic [7:0]  tdata  = 8'h00;
    logic        tvalid = 1'b0;
    logic        tlast  = 1'b0;
    logic        clear  = 1'b0;
    logic        tready;
    logic [7:0]  err_vec;
    logic        err_valid;
    logic        locked;
    logic [47:0] bit_count;
    logic [31:0] err_count;
    logic [15:0] lock_loss_count;

    always #5 clk = ~clk;

    prbs_rx_monitor #(.INV_PATTERN(INV), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_axis_input_tdata  (tdata),
        .s_axis_input_tvalid (tvalid),
        .s_axis_input_tlast  (tlast),
        .s_axis_input_tready (tready),
        .clear_stats         (clear),
        .err_vec             (err_vec),
        .err_valid           (err_valid),
        .locked              (locked),
        .bit_count           (bit_count),
        .err_count           (err_count),
        .lock_loss_count     (lock_loss_count)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic last_ready;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // ---------------- PRBS-31 source (b[n] = b[n-31] ^ b[n-28]) ----------------
    bit       gen_q[$];
    bit [7:0] cur_byte;

    function automatic bit gen_bit();
        bit b;
        b = gen_q[0] ^ gen_q[3];
        gen_q.push_back(b);
        void'(gen_q.pop_front());
        return b;
    endfunction

    function automatic bit [7:0] gen_byte();
        bit [7:0] v;
        for (int i = 7; i >= 0; i--) v[i] = gen_bit() ^ INV_B;
        return v;
    endfunction

    // True when four A5 garbage beats are guaranteed to each contain an error.
    function automatic bit garbage_safe();
        bit       save[$];
        bit [7:0] b2, b3, b4;
        save = gen_q;
        b2 = gen_byte();
        b3 = gen_byte();
        b4 = gen_byte();
        gen_q = save;
        return (cur_byte != 8'hA5) && (b2 != 8'hA5) && (b3 != 8'hA5) && (b4[7:4] != 4'hA);
    endfunction

    // ---------------- reference model ----------------
    bit              m_rq[$];
    bit              m_ready, m_evalid, m_use, m_locked;
    bit [7:0]        m_ev;
    int              m_warm, m_good, m_bad;
    longint unsigned m_bitc, m_errc, m_lossc;

    function automatic bit hist_at(int k);
        return (k < 0) ? 1'b0 : m_rq[k];
    endfunction

    task automatic model_step(input bit t_rst, input bit acc, input bit [7:0] d, input bit clr);
        int pop, n;
        bit r;
        if (t_rst) begin
            m_rq.delete();
            m_ready = 0; m_evalid = 0; m_use = 0; m_locked = 0; m_ev = 8'h00;
            m_warm = 0; m_good = 0; m_bad = 0; m_bitc = 0; m_errc = 0; m_lossc = 0;
            return;
        end
        if (m_evalid && m_use) begin
            pop = $countones(m_ev);
            if (m_locked) begin
                m_bitc += 8;
                m_errc += pop;
                if (pop > 0) begin
                    m_bad++;
                    if (m_bad == LOSS) begin m_locked = 0; m_bad = 0; m_lossc++; end
                end else m_bad = 0;
            end else begin
                if (pop == 0) begin
                    m_good++;
                    if (m_good == LOCK) begin m_locked = 1; m_good = 0; end
                end else m_good = 0;
            end
        end
        if (clr) begin m_bitc = 0; m_errc = 0; m_lossc = 0; end
        m_evalid = acc;
        if (acc) begin
            for (int i = 7; i >= 0; i--) begin
                r = d[i] ^ INV_B;
                n = m_rq.size();
                m_ev[i] = r ^ hist_at(n - 31) ^ hist_at(n - 28);
                m_rq.push_back(r);
            end
            m_use = (m_warm >= 4);
            if (m_warm < 4) m_warm++;
        end
        m_ready = 1;
    endtask

    // One clock: drive, check tready, clock, step model, compare all outputs.
    task automatic tick(input bit t_rst, input bit t_valid, input bit [7:0] t_data, input bit t_clr,
                        output bit acc);
        bit exp_ready;
        rst = t_rst; tvalid = t_valid; tdata = t_data; clear = t_clr;
        tlast = 1'($urandom_range(0, 1));
        #1;
        exp_ready  = !t_rst && m_ready;
        last_ready = tready;
        check_val("tready", tready, exp_ready);
        acc = t_valid && exp_ready;
        @(posedge clk);
        model_step(t_rst, acc, t_data, t_clr);
        #1;
        check_val("err_valid", err_valid, m_evalid);
        check_val("err_vec", err_vec, m_ev);
        check_val("locked", locked, m_locked);
        check_val("bit_count", bit_count, m_bitc);
        check_val("err_count", err_count, m_errc);
        check_val("lock_loss_count", lock_loss_count, m_lossc);
    endtask

    task automatic send_clean(input bit v, input bit clr);
        bit acc;
        tick(1'b0, v, cur_byte, clr, acc);
        if (acc) cur_byte = gen_byte();
    endtask

    // Contiguous clean stream until locked; reports ticks from first accepted beat.
    task automatic acquire_lock(output int lat, output int first);
        int  t;
        bit  acc;
        t = 0;
        first = -1;
        while (locked !== 1'b1 && t < 100) begin
            tick(1'b0, 1'b1, cur_byte, 1'b0, acc);
            t++;
            if (acc) begin
                cur_byte = gen_byte();
                if (first < 0) first = t;
            end
        end
        lat = t - first;
    endtask

    initial begin
        bit       acc, saw_unlock;
        int       lat, first, ev_sum, beats, guard, rr;
        bit [7:0] mask;

        for (int i = 0; i < 31; i++) gen_q.push_back(1'($urandom_range(0, 1)));
        gen_q[0] = 1'b1;
        cur_byte = gen_byte();
        m_ready = 0;

        // Reset and first lock
        repeat (3) tick(1'b1, 1'b0, 8'h00, 1'b0, acc);
        check_val("reset_locked", locked, 1'b0);
        check_val("reset_bit_count", bit_count, 48'd0);
        acquire_lock(lat, first);
        check_val("lock_latency", lat, 20);

        repeat (1000) send_clean(1'b1, 1'b0);
        check_val("run_bit_count", bit_count, 48'd8000);
        check_val("run_err_count", err_count, 32'd0);
        check_val("run_loss_count", lock_loss_count, 16'd0);

        // Single flipped bit: itself plus two tap echoes
        ev_sum = 0;
        tick(1'b0, 1'b1, cur_byte ^ 8'h08, 1'b0, acc);
        if (acc) cur_byte = gen_byte();
        if (err_valid) ev_sum += $countones(err_vec);
        repeat (8) begin
            send_clean(1'b1, 1'b0);
            if (err_valid) ev_sum += $countones(err_vec);
        end
        check_val("flip_err_bits", ev_sum, 3);
        check_val("flip_err_count", err_count, 32'd3);
        check_val("flip_locked", locked, 1'b1);

        // clear_stats on a counted beat wins, then counting resumes
        send_clean(1'b1, 1'b1);
        check_val("clear_bit_count", bit_count, 48'd0);
        check_val("clear_err_count", err_count, 32'd0);
        check_val("clear_locked", locked, 1'b1);
        send_clean(1'b1, 1'b0);
        check_val("clear_resume", bit_count, 48'd8);

        // Garbage burst drops lock, clean stream relocks
        guard = 0;
        while (!garbage_safe() && guard < 200) begin
            send_clean(1'b1, 1'b0);
            guard++;
        end
        repeat (4) tick(1'b0, 1'b1, 8'hA5, 1'b0, acc);
        saw_unlock = 0;
        repeat (21) begin
            send_clean(1'b1, 1'b0);
            if (locked === 1'b0) saw_unlock = 1;
        end
        check_val("garbage_unlock", saw_unlock, 1'b1);
        check_val("garbage_loss_count", lock_loss_count, 16'd1);
        check_val("garbage_relock", locked, 1'b1);

        // 50% tvalid from reset: 100 beats -> beats 21..100 counted
        tick(1'b1, 1'b0, 8'h00, 1'b0, acc);
        beats = 0;
        guard = 0;
        while (beats < 100 && guard < 1000) begin
            tick(1'b0, 1'($urandom_range(0, 1)), cur_byte, 1'b0, acc);
            if (acc) begin cur_byte = gen_byte(); beats++; end
            guard++;
        end
        repeat (3) send_clean(1'b0, 1'b0);
        check_val("gap_bit_count", bit_count, 48'd640);
        check_val("gap_err_count", err_count, 32'd0);
        check_val("gap_loss_count", lock_loss_count, 16'd0);
        check_val("gap_locked", locked, 1'b1);

        // One-cycle reset while locked
        tick(1'b1, 1'b1, cur_byte, 1'b0, acc);
        check_val("rst_tready", last_ready, 1'b0);
        check_val("rst_locked", locked, 1'b0);
        check_val("rst_err_valid", err_valid, 1'b0);
        check_val("rst_err_vec", err_vec, 8'h00);
        check_val("rst_bit_count", bit_count, 48'd0);
        check_val("rst_loss_count", lock_loss_count, 16'd0);
        acquire_lock(lat, first);
        check_val("rst_tready_gap", first, 2);
        check_val("rst_relock_latency", lat, 20);

        // Randomized traffic
        for (int k = 0; k < 2500; k++) begin
            rr = $urandom_range(0, 999);
            if (rr < 2) begin
                tick(1'b1, 1'b0, 8'h00, 1'b0, acc);
            end else if (rr < 17) begin
                mask = 8'h01;
                mask = mask << $urandom_range(0, 7);
                tick(1'b0, 1'b1, cur_byte ^ mask, 1'b0, acc);
                if (acc) cur_byte = gen_byte();
            end else if (rr < 20) begin
                repeat (4) tick(1'b0, 1'b1, 8'($urandom_range(0, 255)), 1'b0, acc);
            end else if (rr < 30) begin
                send_clean(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                send_clean(($urandom_range(0, 3) != 0), 1'b0);
            end
        end
        repeat (3) send_clean(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
